apb_addr_decode: RTL and testbench



---
 rtl/apb_addr_decode_if.sv | 39 +++
 rtl/apb_addr_decode.sv | 90 +++++++++
 tb/tb_apb_addr_decode.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/apb_addr_decode_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_addr_decode_if
//  Purpose  : Bundles the address, rule map and decode results exchanged
//             between a bus front-end (master) and the address decoder
//             (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface apb_addr_decode_if #(
  parameter int unsigned NoIndices = 1,
  parameter int unsigned NoRules   = 1,
  parameter int unsigned AddrWidth = 32
);
  // Derived from NoIndices; never set independently.
  localparam int unsigned IdxWidth = (NoIndices > 1) ? $clog2(NoIndices) : 1;

  logic [AddrWidth-1:0]         addr_i;
  logic [NoRules*32-1:0]        rule_idx_i;
  logic [NoRules*AddrWidth-1:0] rule_start_i;
  logic [NoRules*AddrWidth-1:0] rule_end_i;
  logic                         en_default_idx_i;
  logic [IdxWidth-1:0]          default_idx_i;
  logic [IdxWidth-1:0]          idx_o;
  logic                         dec_valid_o;
  logic                         dec_error_o;

  modport master (
    output addr_i, rule_idx_i, rule_start_i, rule_end_i,
           en_default_idx_i, default_idx_i,
    input  idx_o, dec_valid_o, dec_error_o
  );

  modport slave (
    input  addr_i, rule_idx_i, rule_start_i, rule_end_i,
           en_default_idx_i, default_idx_i,
    output idx_o, dec_valid_o, dec_error_o
  );
endinterface
`default_nettype wire

// File: rtl/apb_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : apb_addr_decode
//  Purpose  : Registered address-map decoder. Matches the address against
//             NoRules half-open [start,end) ranges and returns the target
//             index of the highest-numbered matching rule, with an optional
//             default index on a miss. One cycle of latency.
//  Revision : 1.0  initial release
// ============================================================================
module apb_addr_decode #(
  parameter int unsigned NoIndices = 1,
  parameter int unsigned NoRules   = 1,
  parameter int unsigned AddrWidth = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  apb_addr_decode_if.slave       bus
);

  localparam int unsigned IdxWidth = (NoIndices > 1) ? $clog2(NoIndices) : 1;
  localparam logic [31:0] c_NO_INDICES = 32'(NoIndices);

  logic [AddrWidth-1:0] w_start;
  logic [AddrWidth-1:0] w_end;
  logic [31:0]          w_ridx;
  logic                 w_hit;
  logic [IdxWidth-1:0]  w_hit_idx;
  logic [IdxWidth-1:0]  w_idx;
  logic                 w_valid;
  logic                 w_error;

  logic [IdxWidth-1:0]  r_idx;
  logic                 r_valid;
  logic                 r_error;

  // Scan rules in ascending order so a later (higher-numbered) match
  // overrides an earlier one. Empty ranges (start >= end) fail the compare
  // naturally; out-of-range target indices are skipped explicitly.
  always_comb begin
    w_start   = '0;
    w_end     = '0;
    w_ridx    = '0;
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int r = 0; r < int'(NoRules); r++) begin
      w_start = bus.rule_start_i[r*AddrWidth +: AddrWidth];
      w_end   = bus.rule_end_i[r*AddrWidth +: AddrWidth];
      w_ridx  = bus.rule_idx_i[r*32 +: 32];
      if ((w_ridx < c_NO_INDICES) &&
          (bus.addr_i >= w_start) && (bus.addr_i < w_end)) begin
        w_hit     = 1'b1;
        w_hit_idx = w_ridx[IdxWidth-1:0];
      end
    end
  end

  // Resolve the miss case: default index if enabled, otherwise flag error.
  always_comb begin
    w_idx   = '0;
    w_valid = 1'b0;
    w_error = 1'b0;
    if (w_hit) begin
      w_idx   = w_hit_idx;
      w_valid = 1'b1;
    end else if (bus.en_default_idx_i) begin
      w_idx   = bus.default_idx_i;
    end else begin
      w_error = 1'b1;
    end
  end

  // Single output register stage; reset clears all results immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_idx   <= w_idx;
      r_valid <= w_valid;
      r_error <= w_error;
    end
  end

  assign bus.idx_o       = r_idx;
  assign bus.dec_valid_o = r_valid;
  assign bus.dec_error_o = r_error;

endmodule
`default_nettype wire

// File: tb/tb_apb_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_addr_decode
//  Purpose  : Directed self-checking bench for apb_addr_decode with an
//             8-bit address map of four 4-byte rules starting at 0x10.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_addr_decode;

  localparam int unsigned c_NI = 4;
  localparam int unsigned c_NR = 4;
  localparam int unsigned c_AW = 8;

  logic clk;
  logic rst;

  int n_chk  = 0;
  int n_pass = 0;

  apb_addr_decode_if #(.NoIndices(c_NI), .NoRules(c_NR), .AddrWidth(c_AW)) u_if ();

  apb_addr_decode #(.NoIndices(c_NI), .NoRules(c_NR), .AddrWidth(c_AW)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] idx,
                            input logic [31:0] vld, input logic [31:0] err);
    chk({tag, ".idx"},   32'(u_if.idx_o),       idx);
    chk({tag, ".valid"}, 32'(u_if.dec_valid_o), vld);
    chk({tag, ".error"}, 32'(u_if.dec_error_o), err);
  endtask

  task automatic set_rule(input int r, input logic [31:0] idx,
                          input logic [7:0] s, input logic [7:0] e);
    u_if.rule_idx_i[r*32 +: 32]  = idx;
    u_if.rule_start_i[r*8 +: 8]  = s;
    u_if.rule_end_i[r*8 +: 8]    = e;
  endtask

  task automatic default_map();
    for (int r = 0; r < 4; r++)
      set_rule(r, 32'(r), 8'(8'h10 + 4*r), 8'(8'h14 + 4*r));
  endtask

  // Present an address, then sample 1 time unit after the capturing edge.
  task automatic apply(input logic [7:0] a);
    u_if.addr_i = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    u_if.addr_i           = 8'h18;
    u_if.en_default_idx_i = 1'b0;
    u_if.default_idx_i    = 2'd0;
    u_if.rule_idx_i       = '0;
    u_if.rule_start_i     = '0;
    u_if.rule_end_i       = '0;
    default_map();

    // Reset held: outputs stay cleared while addresses that would hit toggle.
    apply(8'h18); expect_out("rst_a", 0, 0, 0);
    apply(8'h1C); expect_out("rst_b", 0, 0, 0);
    apply(8'h0F); expect_out("rst_c", 0, 0, 0);

    // Release between edges; first result appears at the following edge.
    rst = 1'b0;
    u_if.addr_i = 8'h18;
    #2;
    expect_out("post_rst_hold", 0, 0, 0);
    @(posedge clk); #1;
    expect_out("hit_18", 2, 1, 0);

    apply(8'h1B); expect_out("hit_1b", 2, 1, 0);
    apply(8'h1C); expect_out("hit_1c", 3, 1, 0);
    apply(8'h10); expect_out("hit_10", 0, 1, 0);
    apply(8'h1F); expect_out("hit_1f", 3, 1, 0);

    // Misses without and with default.
    apply(8'h0F); expect_out("miss_0f", 0, 0, 1);
    apply(8'h20); expect_out("miss_20", 0, 0, 1);
    apply(8'hFF); expect_out("miss_ff", 0, 0, 1);
    u_if.en_default_idx_i = 1'b1;
    u_if.default_idx_i    = 2'd3;
    apply(8'h0F); expect_out("dflt_0f", 3, 0, 0);
    apply(8'h20); expect_out("dflt_20", 3, 0, 0);
    apply(8'h14); expect_out("dflt_hit", 1, 1, 0);
    u_if.en_default_idx_i = 1'b0;

    // Overlap: rule0 widened to [0x10,0x20); higher-numbered rule wins.
    set_rule(0, 0, 8'h10, 8'h20);
    apply(8'h19); expect_out("ovl_19", 2, 1, 0);
    apply(8'h11); expect_out("ovl_11", 0, 1, 0);
    apply(8'h1D); expect_out("ovl_1d", 3, 1, 0);
    default_map();

    // Empty rule (start == end) and inverted rule never match.
    set_rule(1, 1, 8'h14, 8'h14);
    apply(8'h14); expect_out("empty_eq", 0, 0, 1);
    set_rule(1, 1, 8'h17, 8'h14);
    apply(8'h15); expect_out("empty_inv", 0, 0, 1);
    default_map();

    // Out-of-range target index is ignored.
    set_rule(3, 7, 8'h1C, 8'h20);
    apply(8'h1C); expect_out("bad_idx", 0, 0, 1);
    set_rule(3, 32'h0000_0103, 8'h1C, 8'h20);
    apply(8'h1C); expect_out("bad_idx_hi", 0, 0, 1);
    default_map();

    // Async reset mid-stream clears outputs before the next edge.
    apply(8'h1C); expect_out("pre_async", 3, 1, 0);
    #2 rst = 1'b1;
    #1 expect_out("async_rst", 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    u_if.addr_i = 8'h0F;
    @(posedge clk); #1;
    expect_out("post_async", 0, 0, 1);

    // Consecutive address changes track with exactly one cycle of lag.
    u_if.addr_i = 8'h10;
    #2 expect_out("lag_hold", 0, 0, 1);
    @(posedge clk); #1; expect_out("lag_10", 0, 1, 0);
    apply(8'h14); expect_out("lag_14", 1, 1, 0);
    apply(8'h18); expect_out("lag_18", 2, 1, 0);
    apply(8'h1C); expect_out("lag_1c", 3, 1, 0);
    apply(8'h13); expect_out("lag_13", 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
